// File: rtl/song_pkg.sv
// Shared constants and types for the phrase playback path: rest code,
// playlist contents, sequencer state encoding and a note-word helper.
package song_pkg;

  localparam logic [3:0] NOTE_REST = 4'hD;
  localparam int         SONG_LEN  = 16;

  // Phrase addresses into phrase_db, in playback order.
  localparam logic [3:0] PLAYLIST [SONG_LEN] = '{
    4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd2, 4'd3, 4'd5,
    4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Note i of a packed 32-bit note word; note 0 sits in the top nibble.
  function automatic logic [3:0] note_nibble(input logic [31:0] word,
                                             input logic [2:0]  idx);
    logic [31:0] shifted;
    shifted = word << {idx, 2'b00};
    return shifted[31:28];
  endfunction

endpackage

// File: rtl/playlist_rom.sv
// Combinational playlist lookup: playlist index to phrase address.
module playlist_rom
  import song_pkg::*;
(
  input  logic [3:0] pl_idx,
  output logic [3:0] phrase
);

  // Pure table lookup; 16 entries cover every 4-bit index.
  always_comb begin
    phrase = PLAYLIST[pl_idx];
  end

endmodule

// File: rtl/note_sequencer.sv
// Playback controller: walks the playlist, presents phrase addresses to
// phrase_db, and turns each returned note word into a timed note stream.
//
// Output handshake: note_valid is a one-cycle strobe that marks the first
// cycle of every new note_code (even when the code repeats); there is no
// back-pressure, the consumer must accept the note in that cycle.
module note_sequencer
  import song_pkg::*;
#(
  parameter int TICKS_8TH = 16,
  parameter bit LOOP      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [3:0]  phrase_addr,
  input  logic [31:0] db_entry,
  input  logic [7:0]  length_entry,
  input  logic [2:0]  n_note,
  output logic [3:0]  note_code,
  output logic        note_valid,
  output logic        playing,
  output logic        song_end,
  output seq_state_t  dbg_state
);

  // Wide enough to hold a quarter note (2 x TICKS_8TH).
  localparam int            CW     = $clog2(2 * TICKS_8TH + 1);
  localparam logic [CW-1:0] EIGHTH = CW'(TICKS_8TH);
  localparam logic [3:0]    LAST_PL = 4'(SONG_LEN - 1);

  seq_state_t    state;
  logic [3:0]    pl_idx;
  logic [2:0]    note_idx;
  logic [CW-1:0] cnt;
  logic [31:0]   sh_db;
  logic [7:0]    sh_len;
  logic [2:0]    sh_n;

  logic [3:0]    pl_next;
  logic [3:0]    next_phrase;
  logic [2:0]    idx_next;
  logic          expired;
  logic          last_note;
  logic          last_entry;
  logic          abort;

  // Duration in cycles for a note given its length bit (1 = quarter).
  function automatic logic [CW-1:0] reload(input logic quarter);
    return quarter ? (EIGHTH << 1) : EIGHTH;
  endfunction

  // pl_idx + 1 wraps 15 -> 0, so the same lookup serves advance and loop.
  assign pl_next    = pl_idx + 4'd1;
  assign idx_next   = note_idx + 3'd1;
  assign expired    = (cnt == CW'(1));
  assign last_note  = (note_idx == sh_n);
  assign last_entry = (pl_idx == LAST_PL);
  assign abort      = !en && ((state == LOAD) || (state == PLAY));
  assign dbg_state  = state;

  playlist_rom u_playlist_rom (
    .pl_idx (pl_next),
    .phrase (next_phrase)
  );

  // Sequencer FSM with all outputs registered; abort outranks expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pl_idx      <= 4'd0;
      note_idx    <= 3'd0;
      cnt         <= '0;
      sh_db       <= 32'd0;
      sh_len      <= 8'd0;
      sh_n        <= 3'd0;
      phrase_addr <= PLAYLIST[0];
      note_code   <= NOTE_REST;
      note_valid  <= 1'b0;
      playing     <= 1'b0;
      song_end    <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      song_end   <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        pl_idx      <= 4'd0;
        note_idx    <= 3'd0;
        cnt         <= '0;
        phrase_addr <= PLAYLIST[0];
        note_code   <= NOTE_REST;
        playing     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            note_code   <= NOTE_REST;
            phrase_addr <= PLAYLIST[0];
            pl_idx      <= 4'd0;
            playing     <= 1'b0;
            if (en) begin
              state   <= LOAD;
              playing <= 1'b1;
            end
          end
          LOAD: begin
            // phrase_addr has been stable a full cycle; capture the ROM word.
            sh_db      <= db_entry;
            sh_len     <= length_entry;
            sh_n       <= n_note;
            note_idx   <= 3'd0;
            note_code  <= note_nibble(db_entry, 3'd0);
            note_valid <= 1'b1;
            cnt        <= reload(length_entry[7]);
            state      <= PLAY;
          end
          PLAY: begin
            if (!expired) begin
              cnt <= cnt - CW'(1);
            end else if (!last_note) begin
              note_idx   <= idx_next;
              note_code  <= note_nibble(sh_db, idx_next);
              note_valid <= 1'b1;
              cnt        <= reload(sh_len[3'd7 - idx_next]);
            end else if (!last_entry) begin
              pl_idx      <= pl_next;
              phrase_addr <= next_phrase;
              state       <= LOAD;
            end else if (LOOP) begin
              pl_idx      <= pl_next;
              phrase_addr <= next_phrase;
              song_end    <= 1'b1;
              state       <= LOAD;
            end else begin
              song_end  <= 1'b1;
              note_code <= NOTE_REST;
              playing   <= 1'b0;
              state     <= DONE;
            end
          end
          DONE: begin
            note_code <= NOTE_REST;
            playing   <= 1'b0;
            if (!en) begin
              state       <= IDLE;
              pl_idx      <= 4'd0;
              phrase_addr <= PLAYLIST[0];
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a looping and a stop-at-end instance share
// clock, reset and enable; each is fed by a local phrase ROM model.
module tb_note_sequencer;

  localparam int T = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  // ---------------- phrase ROM model ----------------
  function automatic logic [31:0] rom_db(input logic [3:0] a);
    case (a)
      4'd1:    return 32'h5A8C_0630;
      4'd5:    return 32'hA8C0_0000;
      default: return 32'h9E37_79B9 ^ {8{a}};
    endcase
  endfunction

  function automatic logic [7:0] rom_len(input logic [3:0] a);
    case (a)
      4'd1:    return 8'h08;
      4'd5:    return 8'hF0;
      default: return {a, ~a} ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [2:0] rom_n(input logic [3:0] a);
    case (a)
      4'd1:    return 3'd6;
      4'd5:    return 3'd3;
      default: return a[2:0] ^ 3'd5;
    endcase
  endfunction

  // ---------------- DUTs (index 0 = stop at end, 1 = loop) ----------------
  logic [3:0] pa_s, pa_l, nc_s, nc_l;
  logic       nv_s, nv_l, pl_s, pl_l, se_s, se_l;
  logic [1:0] st_s, st_l;

  note_sequencer #(.TICKS_8TH(T), .LOOP(1'b0)) u_dut_stop (
    .clk(clk), .rst_n(rst_n), .en(en), .phrase_addr(pa_s),
    .db_entry(rom_db(pa_s)), .length_entry(rom_len(pa_s)), .n_note(rom_n(pa_s)),
    .note_code(nc_s), .note_valid(nv_s), .playing(pl_s), .song_end(se_s),
    .dbg_state(st_s)
  );

  note_sequencer #(.TICKS_8TH(T), .LOOP(1'b1)) u_dut_loop (
    .clk(clk), .rst_n(rst_n), .en(en), .phrase_addr(pa_l),
    .db_entry(rom_db(pa_l)), .length_entry(rom_len(pa_l)), .n_note(rom_n(pa_l)),
    .note_code(nc_l), .note_valid(nv_l), .playing(pl_l), .song_end(se_l),
    .dbg_state(st_l)
  );

  logic [3:0] pa_a [2];
  logic [3:0] nc_a [2];
  logic       nv_a [2];
  logic       pl_a [2];
  logic       se_a [2];
  assign pa_a[0] = pa_s; assign pa_a[1] = pa_l;
  assign nc_a[0] = nc_s; assign nc_a[1] = nc_l;
  assign nv_a[0] = nv_s; assign nv_a[1] = nv_l;
  assign pl_a[0] = pl_s; assign pl_a[1] = pl_l;
  assign se_a[0] = se_s; assign se_a[1] = se_l;

  // ---------------- scoreboard ----------------
  // Entry: {code[3:0], phrase_addr[3:0], hold_cycles[15:0]}
  logic [23:0] exp_q0[$];
  logic [23:0] exp_q1[$];
  int vectors = 0;
  int miscompares = 0;
  int exp_se [2];
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int d, input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  // Note-level timeline of one enabled session of k sampled edges: note 0
  // strobes at edge 2, each note lasts T or 2T, a phrase's last note gets
  // one extra cycle unless the song stops there; en low at edge k+1 cuts
  // the timeline and suppresses anything due at that edge.
  int tb_pl [16] = '{1, 2, 3, 4, 1, 2, 3, 5, 6, 7, 8, 9, 10, 11, 12, 13};

  task automatic model_session(input int k, input int d);
    int t, pl, h, dur, hold;
    bit stop, last, song_last, loop;
    logic [3:0]  a, code;
    logic [31:0] db, sh;
    logic [7:0]  ln;
    logic [2:0]  n;
    loop = (d == 1);
    t = 2; pl = 0; stop = 0; exp_se[d] = 0;
    while (!stop) begin
      a = 4'(tb_pl[pl]);
      db = rom_db(a); ln = rom_len(a); n = rom_n(a);
      for (int i = 0; i <= int'(n); i++) begin
        if (t > k) begin
          stop = 1;
          break;
        end
        dur = ln[7 - i] ? 2 * T : T;
        last = (i == int'(n));
        song_last = last && (pl == 15);
        h = dur + ((last && !(song_last && !loop)) ? 1 : 0);
        hold = (h < k + 1 - t) ? h : (k + 1 - t);
        sh = db << (4 * i);
        code = sh[31:28];
        if (d == 0) exp_q0.push_back({code, a, 16'(hold)});
        else        exp_q1.push_back({code, a, 16'(hold)});
        if (song_last && (t + dur <= k)) exp_se[d]++;
        t += h;
      end
      if (!stop) begin
        if (pl == 15) begin
          if (!loop) stop = 1;
          else pl = 0;
        end else begin
          pl++;
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  bit          open_n [2];
  int          hold_n [2];
  logic [3:0]  got_code [2];
  logic [3:0]  got_addr [2];
  bit          stable [2];
  logic [23:0] cur [2];
  int          se_cnt [2] = '{0, 0};

  task automatic close_note(input int d);
    vectors++;
    if (got_code[d] !== cur[d][23:20] || got_addr[d] !== cur[d][19:16] ||
        hold_n[d] != int'(cur[d][15:0]) || !stable[d]) begin
      miscompares++;
      $display("FAIL note dut%0d: got code %h addr %0d hold %0d stable %0b expected code %h addr %0d hold %0d",
               d, got_code[d], got_addr[d], hold_n[d], stable[d],
               cur[d][23:20], cur[d][19:16], cur[d][15:0]);
    end
    open_n[d] = 0;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!mon_en) begin
        open_n[d] = 0;
        continue;
      end
      if (se_a[d]) se_cnt[d]++;
      if (nv_a[d]) begin
        if (open_n[d]) close_note(d);
        if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe dut%0d: got code %h expected no strobe", d, nc_a[d]);
        end else begin
          cur[d]      = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          open_n[d]   = 1;
          hold_n[d]   = 1;
          got_code[d] = nc_a[d];
          got_addr[d] = pa_a[d];
          stable[d]   = 1;
        end
      end else if (open_n[d]) begin
        if (pl_a[d]) begin
          hold_n[d]++;
          if (nc_a[d] !== got_code[d]) stable[d] = 0;
        end else begin
          close_note(d);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_note_code"}, d, 32'(nc_a[d]), 32'hD);
      chk({tag, "_phrase_addr"}, d, 32'(pa_a[d]), 32'd1);
      chk({tag, "_playing"}, d, 32'(pl_a[d]), 32'd0);
      chk({tag, "_note_valid"}, d, 32'(nv_a[d]), 32'd0);
      chk({tag, "_song_end"}, d, 32'(se_a[d]), 32'd0);
    end
  endtask

  task automatic run_session(input int k);
    int base [2];
    model_session(k, 0);
    model_session(k, 1);
    base[0] = se_cnt[0];
    base[1] = se_cnt[1];
    en = 1'b1;
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (c == 1) begin
          chk("start_playing", d, 32'(pl_a[d]), 32'd1);
          chk("start_no_strobe", d, 32'(nv_a[d]), 32'd0);
        end
        if (c == 2) chk("start_first_strobe", d, 32'(nv_a[d]), 32'd1);
      end
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("leftover_notes", 0, 32'(exp_q0.size()), 32'd0);
    chk("leftover_notes", 1, 32'(exp_q1.size()), 32'd0);
    for (int d = 0; d < 2; d++) begin
      chk("song_end_count", d, 32'(se_cnt[d] - base[d]), 32'(exp_se[d]));
    end
    check_idle("after_session");
    exp_q0.delete();
    exp_q1.delete();
  endtask

  initial begin
    // Reset held: outputs at their reset values.
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    run_session(40);    // phrase 1 in full, then phrase 2 starts
    run_session(17);    // abort on the edge note 4 is due
    run_session(19);    // abort two cycles into the quarter note
    run_session(2500);  // whole song: phrase 5, wrap / stop at end
    for (int r = 0; r < 8; r++) begin
      run_session(int'($urandom_range(2, 400)));
    end

    // Asynchronous reset in the middle of a note.
    mon_en = 1'b0;
    en = 1'b1;
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle("async_reset");
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Playback controller for the phrase ROM (`phrase_db`). It walks a fixed phrase playlist and presents each phrase address to the ROM. It unpacks the returned 32-bit note word, per-note length bits and note count into a timed stream of 4-bit note codes for the tone generator. This block owns all tempo and song-position state; the ROM stays purely combinational.

## Interface
Parameters:
- `TICKS_8TH`, default 16: clock cycles per eighth note. A quarter note lasts 2×`TICKS_8TH` cycles. Legal range 2..1024.
- `LOOP`, default 1: 1 restarts the playlist after the last phrase; 0 stops at song end.

Ports:
- `clk`  in  1: single clock; all state is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: play enable, level-sensitive.
- `phrase_addr`  out  4: registered address to `phrase_db`.
- `db_entry`  in  32: eight 4-bit note codes, note 0 in [31:28], note i in [31-4i -: 4].
- `length_entry`  in  8: note i length in bit [7-i]; 0 = eighth, 1 = quarter.
- `n_note`  in  3: number of notes in the phrase minus 1.
- `note_code`  out  4: current note code; 4'hD = rest.
- `note_valid`  out  1: one-cycle strobe in the first cycle of each new `note_code`.
- `playing`  out  1: high in LOAD and PLAY.
- `song_end`  out  1: one-cycle strobe after the last note of the last playlist entry.

## Operation
- **Playlist:** SONG_LEN = 16 entries of phrase addresses: 1,2,3,4,1,2,3,5,6,7,8,9,10,11,12,13. The playlist index `pl_idx` has 4 bits.
- **IDLE:**
  - `note_code` = D, `playing` = 0.
  - `phrase_addr` = playlist[0].
  - When `en`=1, go to LOAD with `pl_idx`=0.
- **LOAD (1 cycle):**
  - `phrase_addr` is already stable. Latch `db_entry`, `length_entry` and `n_note` into shadow registers.
  - Set `note_idx`=0, emit note 0 (`note_code`, `note_valid`=1), load the duration counter, then go to PLAY.
- **PLAY:**
  - The duration counter counts down to 1.
  - On expiry with `note_idx` < shadow `n_note`: increment `note_idx`, emit the next nibble with `note_valid`, reload the counter.
  - On expiry with `note_idx` = `n_note`:
    - If `pl_idx` < 15: increment `pl_idx`, drive `phrase_addr` = playlist[`pl_idx`+1], go to LOAD.
    - If `pl_idx` = 15 and `LOOP`=1: `pl_idx` wraps to 0 and go to LOAD. `song_end` pulses in this cycle.
    - If `pl_idx` = 15 and `LOOP`=0: pulse `song_end` and go to DONE.
- **DONE:** `note_code` = D, `playing` = 0. Go to IDLE when `en`=0.
- **Abort:** `en`=0 in LOAD or PLAY forces IDLE on the next edge. All counters are cleared and `note_code` = D with no strobe. Abort takes priority over any simultaneous expiry.
- `note_valid` is asserted only on LOAD entry and on note-advance edges. It is asserted even if the new code equals the previous one.
- **Counter width:** $clog2(2×`TICKS_8TH`+1). Reload value is `TICKS_8TH` << length bit.

## Timing
- **Reset values:**
  - `phrase_addr` = 4'd1 (playlist[0]).
  - `note_code` = 4'hD.
  - `note_valid`, `playing`, `song_end` = 0.
  - State = IDLE.
- **Start latency:** `en` rises at edge N; LOAD at N+1; note 0 visible with `note_valid` after edge N+2.
- **Note durations:**
  - Each note other than a phrase's last is held exactly `TICKS_8TH` or 2×`TICKS_8TH` cycles.
  - A phrase's last note is held one extra cycle (the LOAD cycle).
  - A phrase therefore spans sum(durations)+1 cycles.
- `phrase_addr` changes only on the expiry edge that enters LOAD. Inputs are sampled only in LOAD, so the ROM has a full cycle of combinational settling.
- Reset mid-note returns all outputs to reset values immediately (asynchronous).

## Structure
- **Shared package `song_pkg`:**
  - `NOTE_REST` = 4'hD.
  - `SONG_LEN` = 16.
  - The playlist constant array.
  - State enum {IDLE, LOAD, PLAY, DONE}.
- **Sub-module `playlist_rom`:** combinational, input `pl_idx[3:0]`, output `phrase[3:0]`. Instantiated once.
- `phrase_db` is instantiated by the parent, not inside this block.

## Test plan
- **Reset:** assert `rst_n`=0 mid-PLAY → `note_code`=D, `phrase_addr`=1, all strobes 0, without waiting for a clock edge.
- **Phrase 1 sequence:** `TICKS_8TH`=4, real `phrase_db` attached, `en` held → codes 5,A,8,C,0,6,3 with durations 4,4,4,4,8,4,5 cycles; `phrase_addr` then becomes 2.
- **Phrase 5:** reached at `pl_idx` 7 → four notes A,8,C,0, each 8 cycles (last 9); `note_valid` count = 4.
- **Wrap:** `LOOP`=1 → after phrase 13's last note, `song_end` pulses once, `phrase_addr` returns to 1 and playback continues. `LOOP`=0 → DONE, `note_code`=D, `playing`=0 until `en` drops.
- **Abort:** drop `en` 2 cycles into a quarter note → next edge IDLE, `note_code`=D, no `note_valid`. Re-raise `en` → restarts at phrase 1 note 0.
- **Abort priority:** drop `en` on the same edge a note expires → IDLE wins; no advance and no strobe.
